// File: rtl/lfsr_victim_sel.sv
// Pseudo-random victim selector: maximal-length Fibonacci LFSR with seed load and
// zero-lockup guard, mapped onto a one-hot way choice with invalid ways first.
module lfsr_victim_sel #(
  parameter int WIDTH     = 8,
  parameter int NUMWAYS   = 4,
  parameter int RESETSEED = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       LoadSeed,
  input  logic [WIDTH-1:0]           Seed,
  input  logic                       Advance,
  input  logic [NUMWAYS-1:0]         ValidWay,
  output logic [NUMWAYS-1:0]         Victim,
  output logic [$clog2(NUMWAYS)-1:0] VictimIndex,
  output logic [WIDTH-1:0]           State
);

  localparam int IDXW = $clog2(NUMWAYS);

  // Tap n of the polynomial maps to mask bit n-1.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAPS_FULL   = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS        = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STATE_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(RESETSEED);

  generate
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
      $error("lfsr_victim_sel: WIDTH must be in 3..16");
    end
    if (NUMWAYS < 2 || NUMWAYS > 16 || (NUMWAYS & (NUMWAYS - 1)) != 0) begin : g_bad_ways
      $error("lfsr_victim_sel: NUMWAYS must be a power of two in 2..16");
    end
    if (IDXW > WIDTH - 1) begin : g_bad_idxw
      $error("lfsr_victim_sel: log2(NUMWAYS) must not exceed WIDTH-1");
    end
    if (RESETSEED == 0 || RESET_STATE == '0) begin : g_bad_seed
      $error("lfsr_victim_sel: RESETSEED must be non-zero");
    end
  endgenerate

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic             feedback;

  assign feedback = ^(state_reg & TAPS);

  // A zero state (e.g. upset) would lock the register, so stepping from it reloads one.
  always_comb begin
    state_next = {state_reg[WIDTH-2:0], feedback};
    if (state_reg == '0) begin
      state_next = STATE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RESET_STATE;
    end else if (LoadSeed) begin
      state_reg <= (Seed == '0) ? STATE_ONE : Seed;
    end else if (Advance) begin
      state_reg <= state_next;
    end
  end

  assign State = state_reg;

  logic            any_invalid;
  logic [IDXW-1:0] lowest_invalid;

  assign any_invalid = ~&ValidWay;

  // Scanning downwards leaves the lowest-indexed invalid way as the final winner.
  always_comb begin
    lowest_invalid = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!ValidWay[i]) begin
        lowest_invalid = IDXW'(i);
      end
    end
  end

  assign VictimIndex = any_invalid ? lowest_invalid : state_reg[IDXW-1:0];

  generate
    for (genvar gi = 0; gi < NUMWAYS; gi++) begin : g_onehot
      assign Victim[gi] = (VictimIndex == IDXW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_lfsr_victim_sel.sv
// Scoreboard bench for lfsr_victim_sel: step/priority/victim checks on a 4-bit unit,
// zero-seed checks on an 8-bit unit and period checks on every width 3..16.
module tb_lfsr_victim_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 4-bit / 4-way unit with a distinctive reset seed
  logic       reset, load_seed, advance;
  logic [3:0] seed, valid_way, victim, state;
  logic [1:0] victim_index;

  lfsr_victim_sel #(.WIDTH(4), .NUMWAYS(4), .RESETSEED(3)) dut (
    .clk(clk), .reset(reset), .LoadSeed(load_seed), .Seed(seed), .Advance(advance),
    .ValidWay(valid_way), .Victim(victim), .VictimIndex(victim_index), .State(state)
  );

  // 8-bit / 8-way unit
  logic       reset8, load_seed8, advance8;
  logic [7:0] seed8, valid_way8, victim8, state8;
  logic [2:0] victim_index8;

  lfsr_victim_sel #(.WIDTH(8), .NUMWAYS(8), .RESETSEED(1)) dut8 (
    .clk(clk), .reset(reset8), .LoadSeed(load_seed8), .Seed(seed8), .Advance(advance8),
    .ValidWay(valid_way8), .Victim(victim8), .VictimIndex(victim_index8), .State(state8)
  );

  // One unit per width for the period sweep
  logic        per_rst = 1'b1;
  logic        per_adv = 1'b0;
  logic [15:0] per_state [3:16];

  generate
    for (genvar gi = 3; gi <= 16; gi++) begin : g_per
      logic [gi-1:0] st;
      logic [1:0]    vic;
      logic          vidx;
      lfsr_victim_sel #(.WIDTH(gi), .NUMWAYS(2), .RESETSEED(1)) u_lfsr (
        .clk(clk), .reset(per_rst), .LoadSeed(1'b0), .Seed('0), .Advance(per_adv),
        .ValidWay(2'b11), .Victim(vic), .VictimIndex(vidx), .State(st)
      );
      assign per_state[gi] = 16'(st);
    end
  endgenerate

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] vic;
    logic [1:0] idx;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [1:0] model_idx(input logic [3:0] st, input logic [3:0] vw);
    if (vw != 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        if (!vw[i]) return 2'(i);
      end
    end
    return st[1:0];
  endfunction

  // Drive one cycle of stimulus, push the expected result, then compare after the edge.
  task automatic txn(input string tag, input bit rst, input bit ls, input bit adv,
                     input logic [3:0] sd, input logic [3:0] vw, input logic [3:0] exp_st);
    exp_t e;
    exp_t got;
    logic [1:0] ei;
    @(negedge clk);
    reset = rst; load_seed = ls; advance = adv; seed = sd; valid_way = vw;
    ei = model_idx(exp_st, vw);
    e.tag = tag; e.st = exp_st; e.idx = ei; e.vic = 4'b0001 << ei;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    $display("txn %-10s state=%b victim=%b idx=%0d (exp state=%b victim=%b idx=%0d)",
             got.tag, state, victim, victim_index, got.st, got.vic, got.idx);
    chk_val({got.tag, ".state"}, 32'(state), 32'(got.st));
    chk_val({got.tag, ".victim"}, 32'(victim), 32'(got.vic));
    chk_val({got.tag, ".index"}, 32'(victim_index), 32'(got.idx));
  endtask

  int first_ret [3:16];
  bit saw_zero  [3:16];

  initial begin
    reset = 1'b0; load_seed = 1'b0; advance = 1'b0; seed = '0; valid_way = 4'hF;
    reset8 = 1'b1; load_seed8 = 1'b0; advance8 = 1'b0; seed8 = '0; valid_way8 = 8'hFF;

    txn("reset",     1, 0, 0, 4'h0, 4'hF, 4'b0011);
    txn("seed1",     0, 1, 0, 4'h1, 4'hF, 4'b0001);
    txn("adv1",      0, 0, 1, 4'h0, 4'hF, 4'b0010);
    txn("adv2",      0, 0, 1, 4'h0, 4'hF, 4'b0100);
    txn("adv3",      0, 0, 1, 4'h0, 4'hF, 4'b1001);
    txn("ld_adv",    0, 1, 1, 4'h5, 4'hF, 4'b0101);
    txn("rst_ld",    1, 1, 0, 4'h6, 4'hF, 4'b0011);
    txn("seedB",     0, 1, 0, 4'hB, 4'hF, 4'b1011);
    txn("vw1011",    0, 0, 0, 4'h0, 4'b1011, 4'b1011);
    txn("vw1111",    0, 0, 0, 4'h0, 4'b1111, 4'b1011);
    txn("vw0000",    0, 0, 0, 4'h0, 4'b0000, 4'b1011);
    txn("vw0111",    0, 0, 0, 4'h0, 4'b0111, 4'b1011);
    for (int i = 0; i < 10; i++) txn("hold", 0, 0, 0, 4'h0, 4'hF, 4'b1011);
    txn("seed0",     0, 1, 0, 4'h0, 4'hF, 4'b0001);
    txn("adv_z",     0, 0, 1, 4'h0, 4'hF, 4'b0010);
    txn("adv_z2",    0, 0, 1, 4'h0, 4'hF, 4'b0100);
    txn("rst_adv",   1, 0, 1, 4'h0, 4'hF, 4'b0011);
    txn("adv_rst1",  0, 0, 1, 4'h0, 4'hF, 4'b0110);
    reset = 1'b0; load_seed = 1'b0; advance = 1'b0;

    // 8-bit unit: reset, non-zero seed, zero seed, then one step
    @(posedge clk); #1;
    chk_val("w8.reset", 32'(state8), 32'h01);
    @(negedge clk); reset8 = 1'b0; load_seed8 = 1'b1; seed8 = 8'h5A;
    @(posedge clk); #1;
    chk_val("w8.seed5a", 32'(state8), 32'h5A);
    @(negedge clk); seed8 = 8'h00;
    @(posedge clk); #1;
    chk_val("w8.seed0", 32'(state8), 32'h01);
    @(negedge clk); load_seed8 = 1'b0; advance8 = 1'b1; valid_way8 = 8'hF7;
    @(posedge clk); #1;
    chk_val("w8.adv", 32'(state8), 32'h02);
    chk_val("w8.idx", 32'(victim_index8), 32'd3);
    chk_val("w8.victim", 32'(victim8), 32'h08);
    @(negedge clk); advance8 = 1'b0;

    // Period sweep: all widths stepped in parallel from seed 1
    for (int w = 3; w <= 16; w++) begin
      first_ret[w] = 0;
      saw_zero[w] = 1'b0;
    end
    @(negedge clk); per_rst = 1'b1; per_adv = 1'b0;
    @(negedge clk); per_rst = 1'b0; per_adv = 1'b1;
    for (int cyc = 1; cyc <= 65536; cyc++) begin
      @(posedge clk); #1;
      for (int w = 3; w <= 16; w++) begin
        if (per_state[w] == 16'd0) saw_zero[w] = 1'b1;
        if (per_state[w] == 16'd1 && first_ret[w] == 0) first_ret[w] = cyc;
      end
    end
    per_adv = 1'b0;
    for (int w = 3; w <= 16; w++) begin
      $display("period width=%0d first_return=%0d zero_seen=%0d", w, first_ret[w], saw_zero[w]);
      chk_val($sformatf("period.w%0d", w), 32'(first_ret[w]), (32'd1 << w) - 32'd1);
      chk_val($sformatf("nonzero.w%0d", w), 32'(saw_zero[w]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lfsr_victim_sel.md
# lfsr_victim_sel

Parametrised pseudo-random victim selector for set-associative caches. Holds a maximal-length Fibonacci LFSR of configurable width with built-in tap selection, seed load and zero-lockup protection. Maps the LFSR state onto a way choice for NUMWAYS ways, giving strict priority to invalid ways. It sits beside the cache replacement logic and is advanced once per line fill.

## Interface
- WIDTH, default 8: LFSR width; legal range 3..16.
- NUMWAYS, default 4: cache associativity; power of two, 2..16.
- RESETSEED, default 1: LFSR value loaded on reset; must be non-zero.
- Elaboration error if WIDTH is out of range, if NUMWAYS is not a legal power of two, if log2(NUMWAYS) > WIDTH-1, or if RESETSEED == 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- LoadSeed  in  1  load Seed into the LFSR at the next edge.
- Seed  in  WIDTH  seed value.
- Advance  in  1  step the LFSR one position at the next edge.
- ValidWay  in  NUMWAYS  per-way valid bits of the addressed set.
- Victim  out  NUMWAYS  one-hot selected way.
- VictimIndex  out  log2(NUMWAYS)  binary index of the selected way.
- State  out  WIDTH  current LFSR contents, for debug and checking.

## Operation
- Register: State[WIDTH-1:0].
- Step: next = {State[WIDTH-2:0], fb}. fb is the XOR of the tapped bits. Tap n refers to State[n-1].
- Taps by WIDTH:
  - 3: (3,2); 4: (4,3); 5: (5,3); 6: (6,5); 7: (7,6)
  - 8: (8,6,5,4); 9: (9,5); 10: (10,7); 11: (11,9)
  - 12: (12,6,4,1); 13: (13,4,3,1); 14: (14,5,3,1)
  - 15: (15,14); 16: (16,15,13,4)
- Every tap set gives period 2^WIDTH-1 from any non-zero state.
- Priority at each edge: reset > LoadSeed > Advance > hold.
  - reset: State <= RESETSEED.
  - LoadSeed: State <= Seed. If Seed == 0, State <= 1 instead.
  - Advance: State <= next.
  - otherwise: State holds.
- Zero lockup: State never becomes 0 through any path. If State is 0 for any reason (e.g. SEU), the next Advance loads 1.
- Victim selection (combinational from State and ValidWay):
  - If any ValidWay bit is 0: Victim = one-hot of the lowest-indexed invalid way.
  - Else: VictimIndex = State[log2(NUMWAYS)-1:0], and Victim is its one-hot decode.
  - VictimIndex and Victim are always consistent, and Victim is exactly one-hot.
- LoadSeed and Advance together in the same cycle: LoadSeed wins and the step is lost. There is no load-then-step.
- Advance while reset is high is ignored.

## Timing
- Reset value after a reset edge: State = RESETSEED. Victim and VictimIndex follow combinationally from RESETSEED and ValidWay.
- LoadSeed or Advance sampled at edge N: the new State is visible after edge N, so the earliest effect is cycle N+1.
- Victim and VictimIndex have zero latency from ValidWay and State. There is no register on the output path.
- Advance may be held high continuously: one step per cycle, no bubbles.
- Reset asserted mid-sequence: the LFSR restarts from RESETSEED at the next edge, and the sequence restarts from its first value.

## Test plan
- Step sequence, WIDTH=4, NUMWAYS=4: LoadSeed with Seed=0001, then Advance for 3 cycles -> State = 0010, 0100, 1001.
- Period check for every WIDTH 3..16: seed 1, then Advance continuously -> State first returns to 1 after exactly 2^WIDTH-1 steps, and State is never 0.
- Zero seed, WIDTH=8: LoadSeed with Seed=0 -> State = 00000001. Then one Advance -> State = 00000010.
- Priority: LoadSeed and Advance together with Seed=0101 -> State = 0101 with no step applied. Reset together with LoadSeed -> State = RESETSEED.
- Invalid-way priority, NUMWAYS=4, State=1011:
  - ValidWay=1011 -> Victim=0100, VictimIndex=2.
  - ValidWay=1111 -> VictimIndex=3, Victim=1000.
  - ValidWay=0000 -> Victim=0001.
- Hold: Advance=0 for 10 cycles -> State unchanged. Mid-run reset -> State = RESETSEED after one edge.
